// File: rtl/cache_miss_ctrl_pkg.sv
// rtl/cache_miss_ctrl_pkg.sv - shared widths and FSM state encodings for the cache miss controller
package cache_miss_ctrl_pkg;

   localparam int LINE_W = 6;
   localparam int DATA_W = 128;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WB     = 3'd1,
      ST_REFILL = 3'd2,
      ST_FILL   = 3'd3,
      ST_REPLAY = 3'd4
   } state_t;

endpackage

// File: rtl/cache_miss_ctrl_if.sv
// rtl/cache_miss_ctrl_if.sv - CPU/cache request and memory-side signals of the miss controller
interface cache_miss_ctrl_if;
   import cache_miss_ctrl_pkg::*;

   logic              req;
   logic              req_we;
   logic [LINE_W-1:0] req_line;
   logic              hit;
   logic              dirty;
   logic [LINE_W-1:0] victim_line;
   logic              ready;
   logic              stall;
   logic [LINE_W-1:0] mem_addr;
   logic              writeback;
   logic              update;

   modport master (
      output req, req_we, req_line, hit, dirty, victim_line,
      input  ready, stall, mem_addr, writeback, update
   );

   modport slave (
      input  req, req_line, hit, dirty, victim_line,
      output ready, stall, mem_addr, writeback, update
   );

endinterface

// File: rtl/cache_miss_ctrl_sat_counter.sv
// rtl/cache_miss_ctrl_sat_counter.sv - saturating event counter; clear wins over increment
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/cache_miss_ctrl.sv
// rtl/cache_miss_ctrl.sv - hit / refill / writeback+refill sequencer with saturating statistics
module cache_miss_ctrl
   import cache_miss_ctrl_pkg::*;
#(
   parameter int MEM_LAT = 2,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   cache_miss_ctrl_if.slave bus,
   input  logic             stat_clr,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt,
   output logic [CNT_W-1:0] wb_cnt
);

   localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

   state_t            st;
   logic [3:0]        lat;
   logic [LINE_W-1:0] vic_l;
   logic [LINE_W-1:0] req_l;
   logic              hit_ev;
   logic              miss_ev;
   logic              wb_ev;

   assign hit_ev  = (st == ST_IDLE) && bus.req && bus.hit;
   assign miss_ev = (st == ST_IDLE) && bus.req && !bus.hit;
   assign wb_ev   = miss_ev && bus.dirty;
   assign state   = st;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st    <= ST_IDLE;
         lat   <= '0;
         vic_l <= '0;
         req_l <= '0;
      end else begin
         case (st)
            ST_IDLE: begin
               if (miss_ev) begin
                  req_l <= bus.req_line;
                  lat   <= '0;
                  if (bus.dirty) begin
                     vic_l <= bus.victim_line;
                     st    <= ST_WB;
                  end else begin
                     st    <= ST_REFILL;
                  end
               end
            end
            ST_WB: begin
               if (lat == LAT_LAST) begin
                  lat <= '0;
                  st  <= ST_REFILL;
               end else begin
                  lat <= lat + 4'd1;
               end
            end
            ST_REFILL: begin
               if (lat == LAT_LAST) begin
                  lat <= '0;
                  st  <= ST_FILL;
               end else begin
                  lat <= lat + 4'd1;
               end
            end
            ST_FILL:   st <= ST_REPLAY;
            ST_REPLAY: st <= ST_IDLE;
            default:   st <= ST_IDLE;
         endcase
      end
   end

   // Outputs are quiet while reset is held so no strobe escapes an abandoned access.
   always_comb begin
      bus.ready     = 1'b0;
      bus.stall     = 1'b0;
      bus.writeback = 1'b0;
      bus.update    = 1'b0;
      bus.mem_addr  = '0;
      if (reset) begin
         case (st)
            ST_IDLE: begin
               bus.mem_addr = bus.req_line;
               bus.ready    = bus.req && bus.hit;
               bus.stall    = bus.req && !bus.hit;
            end
            ST_WB: begin
               bus.mem_addr  = vic_l;
               bus.stall     = 1'b1;
               bus.writeback = (lat == 4'd0);
            end
            ST_REFILL: begin
               bus.mem_addr = req_l;
               bus.stall    = 1'b1;
            end
            ST_FILL: begin
               bus.mem_addr = req_l;
               bus.stall    = 1'b1;
               bus.update   = 1'b1;
            end
            ST_REPLAY: begin
               bus.mem_addr = req_l;
               bus.ready    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_hit_cnt (
      .clk(clk), .reset(reset), .inc(hit_ev), .clr(stat_clr), .count(hit_cnt)
   );

   sat_counter #(.W(CNT_W)) u_miss_cnt (
      .clk(clk), .reset(reset), .inc(miss_ev), .clr(stat_clr), .count(miss_cnt)
   );

   sat_counter #(.W(CNT_W)) u_wb_cnt (
      .clk(clk), .reset(reset), .inc(wb_ev), .clr(stat_clr), .count(wb_cnt)
   );

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb/tb_cache_miss_ctrl.sv - two controller instances (MEM_LAT 2/CNT_W 16, MEM_LAT 3/CNT_W 4) against a schedule model
module tb_cache_miss_ctrl;
   import cache_miss_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       stat_clr = 1'b0;
   logic       req = 1'b0, req_we = 1'b0, hit = 1'b0, dirty = 1'b0;
   logic [5:0] req_line = 6'd0, victim_line = 6'd0;

   cache_miss_ctrl_if bus_a ();
   cache_miss_ctrl_if bus_b ();

   assign bus_a.req = req;   assign bus_a.req_we = req_we; assign bus_a.req_line = req_line;
   assign bus_a.hit = hit;   assign bus_a.dirty = dirty;   assign bus_a.victim_line = victim_line;
   assign bus_b.req = req;   assign bus_b.req_we = req_we; assign bus_b.req_line = req_line;
   assign bus_b.hit = hit;   assign bus_b.dirty = dirty;   assign bus_b.victim_line = victim_line;

   logic [2:0]  state_a, state_b;
   logic [15:0] hit_a, miss_a, wb_a;
   logic [3:0]  hit_b, miss_b, wb_b;

   cache_miss_ctrl #(.MEM_LAT(2), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a), .stat_clr(stat_clr),
      .state(state_a), .hit_cnt(hit_a), .miss_cnt(miss_a), .wb_cnt(wb_a)
   );

   cache_miss_ctrl #(.MEM_LAT(3), .CNT_W(4)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b), .stat_clr(stat_clr),
      .state(state_b), .hit_cnt(hit_b), .miss_cnt(miss_b), .wb_cnt(wb_b)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a miss is a precomputed per-cycle schedule of expected outputs.
   typedef struct {
      logic [2:0] st;
      logic       stall;
      logic       ready;
      logic       wb;
      logic       upd;
      logic [5:0] addr;
      logic       addr_care;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   mh[2], mm[2], mw[2];

   task automatic build(input int L, input logic d, input logic [5:0] v, input logic [5:0] r,
                        output exp_t s[$]);
      exp_t e;
      s = {};
      if (d) begin
         for (int i = 0; i < L; i++) begin
            e = '{3'd1, 1'b1, 1'b0, (i == 0), 1'b0, v, 1'b1};
            s.push_back(e);
         end
      end
      for (int i = 0; i < L; i++) begin
         e = '{3'd2, 1'b1, 1'b0, 1'b0, 1'b0, r, 1'b1};
         s.push_back(e);
      end
      e = '{3'd3, 1'b1, 1'b0, 1'b0, 1'b1, r, 1'b1};
      s.push_back(e);
      e = '{3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0};
      s.push_back(e);
   endtask

   task automatic advance(input int k, input int L, input int maxc);
      exp_t s[$];
      int   n;
      n = (k == 0) ? q_a.size() : q_b.size();
      if (!reset) begin
         if (k == 0) q_a = {}; else q_b = {};
         mh[k] = 0; mm[k] = 0; mw[k] = 0;
      end else begin
         if (n != 0) begin
            if (k == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
         end else if (req) begin
            if (hit) begin
               if (mh[k] < maxc) mh[k]++;
            end else begin
               if (mm[k] < maxc) mm[k]++;
               if (dirty && mw[k] < maxc) mw[k]++;
               build(L, dirty, victim_line, req_line, s);
               if (k == 0) q_a = s; else q_b = s;
            end
         end
         if (stat_clr) begin
            mh[k] = 0; mm[k] = 0; mw[k] = 0;
         end
      end
   endtask

   always @(posedge clk) begin
      advance(0, 2, 65535);
      advance(1, 3, 15);
   end

   task automatic get_exp(input int k, output exp_t e);
      int n;
      n = (k == 0) ? q_a.size() : q_b.size();
      if (!reset)
         e = '{3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1};
      else if (n == 0)
         e = '{3'd0, req && !hit, req && hit, 1'b0, 1'b0, req_line, 1'b1};
      else if (k == 0)
         e = q_a[0];
      else
         e = q_b[0];
   endtask

   task automatic compare(input int k, input logic [2:0] st, input logic stall, input logic ready,
                          input logic wb, input logic upd, input logic [5:0] addr,
                          input int h, input int m, input int w);
      exp_t  e;
      string p;
      p = (k == 0) ? "a" : "b";
      get_exp(k, e);
      chk({p, ".state"}, st, e.st);
      chk({p, ".stall"}, stall, e.stall);
      chk({p, ".ready"}, ready, e.ready);
      chk({p, ".writeback"}, wb, e.wb);
      chk({p, ".update"}, upd, e.upd);
      if (e.addr_care) chk({p, ".mem_addr"}, addr, e.addr);
      chk({p, ".hit_cnt"}, h, reset ? mh[k] : 0);
      chk({p, ".miss_cnt"}, m, reset ? mm[k] : 0);
      chk({p, ".wb_cnt"}, w, reset ? mw[k] : 0);
   endtask

   always @(negedge clk) begin
      compare(0, state_a, bus_a.stall, bus_a.ready, bus_a.writeback, bus_a.update, bus_a.mem_addr,
              hit_a, miss_a, wb_a);
      compare(1, state_b, bus_b.stall, bus_b.ready, bus_b.writeback, bus_b.update, bus_b.mem_addr,
              hit_b, miss_b, wb_b);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset held with a live hit request: outputs must stay quiet
      req = 1'b1; hit = 1'b1; req_line = 6'h15;
      tick();
      @(negedge clk);
      chk("lit.reset_state", state_a, 0);
      chk("lit.reset_ready", bus_a.ready, 0);
      chk("lit.reset_addr", bus_a.mem_addr, 0);
      chk("lit.reset_hit_cnt", hit_a, 0);
      tick();
      reset = 1'b1;

      // hit stream
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("lit.hit_ready", bus_a.ready, 1);
         chk("lit.hit_stall", bus_a.stall, 0);
         tick();
      end
      req = 1'b0;
      @(negedge clk);
      chk("lit.hit_cnt5", hit_a, 5);
      chk("lit.miss_cnt0", miss_a, 0);

      // clean miss on line 0x09
      tick();
      req = 1'b1; hit = 1'b0; dirty = 1'b0; req_line = 6'h09; victim_line = 6'h2A;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("lit.clean_stall", bus_a.stall, (c < 4) ? 1 : 0);
         chk("lit.clean_update", bus_a.update, (c == 3) ? 1 : 0);
         chk("lit.clean_ready", bus_a.ready, (c == 4) ? 1 : 0);
         chk("lit.clean_wb", bus_a.writeback, 0);
         if (c < 4) chk("lit.clean_addr", bus_a.mem_addr, 9);
         tick();
      end
      req = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      @(negedge clk);
      chk("lit.clean_miss_cnt", miss_a, 1);
      chk("lit.clean_wb_cnt", wb_a, 0);

      // dirty miss, with req dropped and req_line disturbed during refill
      tick();
      req = 1'b1; hit = 1'b0; dirty = 1'b1; req_line = 6'h01; victim_line = 6'h3F;
      for (int c = 0; c < 7; c++) begin
         if (c == 3) begin
            req = 1'b0; req_line = 6'h22; victim_line = 6'h05;
         end
         @(negedge clk);
         chk("lit.dirty_wb", bus_a.writeback, (c == 1) ? 1 : 0);
         if (c == 1 || c == 2) chk("lit.dirty_vic_addr", bus_a.mem_addr, 6'h3F);
         if (c >= 3 && c <= 5) chk("lit.dirty_req_addr", bus_a.mem_addr, 6'h01);
         chk("lit.dirty_update", bus_a.update, (c == 5) ? 1 : 0);
         chk("lit.dirty_ready", bus_a.ready, (c == 6) ? 1 : 0);
         tick();
      end
      @(negedge clk);
      chk("lit.dirty_idle", state_a, 0);
      chk("lit.dirty_wb_cnt", wb_a, 1);
      chk("lit.dirty_miss_cnt", miss_a, 2);
      for (int i = 0; i < 8; i++) tick();

      // reset in the cycle after a dirty miss is accepted
      req = 1'b1; hit = 1'b0; dirty = 1'b1; req_line = 6'h11; victim_line = 6'h10;
      @(negedge clk);
      chk("lit.rst_accept_stall", bus_a.stall, 1);
      tick();
      reset = 1'b0; req = 1'b0;
      @(negedge clk);
      chk("lit.rst_state", state_a, 0);
      chk("lit.rst_writeback", bus_a.writeback, 0);
      chk("lit.rst_miss_cnt", miss_a, 0);
      chk("lit.rst_wb_cnt", wb_a, 0);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("lit.rst_no_update", bus_a.update, 0);
         chk("lit.rst_stays_idle", state_a, 0);
         tick();
      end

      // saturation on the 4-bit instance, then clear against a hit
      req = 1'b1; hit = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      req = 1'b0;
      @(negedge clk);
      chk("lit.sat_hit_b", hit_b, 15);
      chk("lit.nosat_hit_a", hit_a, 20);
      tick();
      req = 1'b1; hit = 1'b1; stat_clr = 1'b1;
      tick();
      req = 1'b0; stat_clr = 1'b0;
      @(negedge clk);
      chk("lit.clr_hit_a", hit_a, 0);
      chk("lit.clr_hit_b", hit_b, 0);
      tick();

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         req         = ($urandom_range(0, 3) != 0);
         req_we      = $urandom_range(0, 1) != 0;
         hit         = $urandom_range(0, 1) != 0;
         dirty       = $urandom_range(0, 1) != 0;
         req_line    = 6'($urandom_range(0, 63));
         victim_line = 6'($urandom_range(0, 63));
         stat_clr    = ($urandom_range(0, 149) == 0);
         reset       = ($urandom_range(0, 399) != 0);
         tick();
      end
      reset = 1'b1; req = 1'b0; stat_clr = 1'b0;
      for (int i = 0; i < 12; i++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cache_miss_ctrl.md
Name: cache_miss_ctrl

Overview:
- Multi-cycle controller between the direct-mapped data cache and the 64-line x 128-bit data memory.
- On each CPU access it decides between three outcomes:
  - a hit, completed at once;
  - a clean miss, handled as a refill;
  - a dirty miss, handled as a writeback followed by a refill.
- Drives the memory line address, the memory write enable (writeback) and the cache update strobe. Stalls the CPU FSM until the access completes.
- Keeps saturating hit, miss and writeback statistics counters for the board display.

Parameters:
- MEM_LAT, 2: memory cycles per writeback or refill phase; legal range 1..15.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock (the divided CPU clock); all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  CPU access valid; held high until ready.
- req_we  in  1  access is a store; informational only, no effect on sequencing.
- req_line  in  6  memory line index of the requested address.
- hit  in  1  cache tag match for req_line; combinational from the cache.
- dirty  in  1  victim line dirty; combinational from the cache.
- victim_line  in  6  memory line index of the resident victim.
- stat_clr  in  1  synchronous clear of all statistics counters.
- ready  out  1  access complete this cycle.
- stall  out  1  CPU must hold its state.
- mem_addr  out  6  memory line address.
- writeback  out  1  memory write enable.
- update  out  1  cache refill strobe.
- state  out  3  encoded FSM state, for debug display.
- hit_cnt  out  CNT_W  number of hits.
- miss_cnt  out  CNT_W  number of misses.
- wb_cnt  out  CNT_W  number of writebacks.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE;
  - lat counter 0 and latched lines 0;
  - all counters 0;
  - ready=0, writeback=0, update=0, stall=0, mem_addr=0.
- Reset mid-operation abandons any writeback or refill; no strobe is issued afterwards.
- Outputs ready, stall, writeback, update and mem_addr are decoded combinationally from the state and the inputs; the state output is registered.
- State encoding: IDLE=0, WB=1, REFILL=2, FILL=3, REPLAY=4.
- IDLE:
  - mem_addr=req_line.
  - req=1 and hit=1: ready=1 in the same cycle (zero-latency hit); hit_cnt increments; stay in IDLE.
  - req=1, hit=0, dirty=1:
    - latch victim_line into vic_l and req_line into req_l;
    - miss_cnt and wb_cnt increment; lat=0;
    - go to WB; stall=1 in this cycle.
  - req=1, hit=0, dirty=0: latch req_l; miss_cnt increments; lat=0; go to REFILL; stall=1.
  - req=0: no action; victim_line, dirty and hit are ignored.
- WB:
  - mem_addr=vic_l; stall=1.
  - writeback=1 only while lat==0, so exactly one memory write occurs per WB phase.
  - lat increments each cycle; when lat==MEM_LAT-1, clear lat and go to REFILL.
- REFILL:
  - mem_addr=req_l; stall=1.
  - lat counts 0..MEM_LAT-1, then FILL.
- FILL:
  - mem_addr=req_l; update=1 for exactly one cycle; stall=1.
  - The cache captures the memory read data on this edge.
  - Go to REPLAY.
- REPLAY:
  - ready=1, stall=0 for one cycle; no counter changes.
  - Go to IDLE. The next access, if any, is evaluated in IDLE.
- Latency:
  - hit: 0 extra cycles;
  - clean miss: MEM_LAT+2 cycles from acceptance to ready;
  - dirty miss: 2*MEM_LAT+2 cycles.
- req dropping during WB, REFILL or FILL has no effect: the sequence completes and the line is still filled. In REPLAY, ready asserts regardless of req.
- Changes on req_line or victim_line while the FSM is not in IDLE are ignored; the latched copies are used.
- Counters:
  - saturate at 2^CNT_W-1 with no wrap;
  - stat_clr has priority over an increment in the same cycle;
  - stat_clr does not affect the FSM.
- writeback and update are never both 1. writeback=1 implies state WB.

Decomposition:
- Shared package/header holds:
  - the state encodings ST_IDLE..ST_REPLAY;
  - the 6-bit line-index width constant LINE_W=6;
  - the 128-bit line width constant.
- One sub-module, sat_counter (width parameter; inputs inc and clr), instantiated three times.
- The FSM and the latency counter stay in the top.

Test Plan:
- Hit stream: reset, then req=1, hit=1 for 5 cycles -> ready=1 each cycle, stall=0, hit_cnt=5, miss_cnt=0.
- Clean miss, MEM_LAT=2, req_line=0x09, hit=0, dirty=0:
  - stall for 4 cycles; mem_addr=0x09 throughout;
  - update=1 on cycle 3 only; ready on cycle 4;
  - miss_cnt=1, wb_cnt=0; writeback never asserted.
- Dirty miss, MEM_LAT=2, victim_line=0x3F, req_line=0x01:
  - writeback=1 only on cycle 1 with mem_addr=0x3F;
  - mem_addr=0x01 from cycle 3; update on cycle 5; ready on cycle 6;
  - wb_cnt=1.
- Input disturbance: drop req and change req_line to 0x22 during REFILL -> mem_addr stays 0x01, update and ready still occur, FSM returns to IDLE.
- Reset during WB: pulse reset low in the cycle after acceptance -> state=0, all counters 0, no update pulse afterwards.
- Saturation with CNT_W=4: 20 hits -> hit_cnt=15. stat_clr together with a hit -> hit_cnt=0.
